multicycle_ctrl: RTL and testbench

Control sequencer for the multicycle variant of the MIPS-subset CPU. It replaces the combinational opcode decoder with a Moore/Mealy FSM. The FSM steps a shared datapath (one ALU, one single-ported memory, instruction register, ALUOut register) through fetch, decode, execute, memory and writeback. Memory access uses a variable-latency req/ready handshake, and the block counts retired instructions.

---
 rtl/multicycle_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control sequencer: Moore/Mealy FSM that steps a shared
// datapath through fetch/decode/execute/memory/writeback and counts retired instructions.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        alu_srcA,
  output logic [1:0]  alu_srcB,
  output logic [2:0]  alu_op,
  output logic        reg_we,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wd_sel,
  output logic        instr_done,
  output logic        illegal,
  output logic [31:0] instr_count,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_INIT     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_WB_ALU   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12,
    S_JR       = 4'd13,
    S_HALT     = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd3;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_instr_count;
  logic        w_rtype;
  logic        w_funct_alu;

  assign w_rtype     = (opcode == OP_RTYPE);
  assign w_funct_alu = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_SLT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_next;
    end
  end

  // Retired-instruction counter; wraps naturally at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr_count <= 32'd0;
    end else if (instr_done) begin
      r_instr_count <= r_instr_count + 32'd1;
    end
  end

  always_comb begin
    w_next     = r_state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'd0;
    alu_srcA   = 1'b0;
    alu_srcB   = 2'd0;
    alu_op     = ALU_ADD;
    reg_we     = 1'b0;
    reg_dst    = 2'd0;
    wd_sel     = 2'd0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (r_state)
      S_INIT: w_next = S_FETCH;
      S_FETCH: begin
        mem_req  = 1'b1;
        alu_srcB = 2'd1;
        if (mem_ready) begin
          ir_we  = 1'b1;
          pc_we  = 1'b1;
          w_next = S_DECODE;
        end
      end
      // ALU computes the branch target here so BRANCH can use ALUOut.
      S_DECODE: begin
        alu_srcB = 2'd3;
        case (opcode)
          OP_RTYPE: begin
            if (w_funct_alu)         w_next = S_EXEC_R;
            else if (funct == FN_JR) w_next = S_JR;
            else                     w_next = S_HALT;
          end
          OP_ADDI, OP_XORI: w_next = S_EXEC_I;
          OP_LW, OP_SW:     w_next = S_MEM_ADDR;
          OP_BEQ, OP_BNE:   w_next = S_BRANCH;
          OP_J:             w_next = S_JUMP;
          OP_JAL:           w_next = S_JAL;
          default:          w_next = S_HALT;
        endcase
      end
      S_EXEC_R: begin
        alu_srcA = 1'b1;
        case (funct)
          FN_SUB:  alu_op = ALU_SUB;
          FN_SLT:  alu_op = ALU_SLT;
          default: alu_op = ALU_ADD;
        endcase
        w_next = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_srcA = 1'b1;
        alu_srcB = 2'd2;
        alu_op   = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
        w_next   = S_WB_ALU;
      end
      S_WB_ALU: begin
        reg_we     = 1'b1;
        wd_sel     = 2'd1;
        reg_dst    = w_rtype ? 2'd1 : 2'd0;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_srcA = 1'b1;
        alu_srcB = 2'd2;
        w_next   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) w_next = S_WB_MEM;
      end
      S_WB_MEM: begin
        reg_we     = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          w_next     = S_FETCH;
        end
      end
      S_BRANCH: begin
        alu_srcA   = 1'b1;
        alu_op     = ALU_SUB;
        pc_src     = 2'd3;
        pc_we      = (opcode == OP_BNE) ? ~zero : zero;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_JUMP: begin
        pc_we      = 1'b1;
        pc_src     = 2'd1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      // Link writes the current PC (already PC+4) before the jump lands.
      S_JAL: begin
        pc_we      = 1'b1;
        pc_src     = 2'd1;
        reg_we     = 1'b1;
        reg_dst    = 2'd2;
        wd_sel     = 2'd2;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_JR: begin
        pc_we      = 1'b1;
        pc_src     = 2'd2;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_HALT: begin
        illegal = 1'b1;
        w_next  = S_HALT;
      end
      default: w_next = S_HALT;
    endcase
  end

  assign instr_count = r_instr_count;
  assign state       = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-cycle expected output vectors are queued as
// stimulus is driven and popped when the DUT outputs are sampled at negedge.
module tb_multicycle_ctrl;

  logic        clk;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        iord;
  logic        ir_we;
  logic        pc_we;
  logic [1:0]  pc_src;
  logic        alu_srcA;
  logic [1:0]  alu_srcB;
  logic [2:0]  alu_op;
  logic        reg_we;
  logic [1:0]  reg_dst;
  logic [1:0]  wd_sel;
  logic        instr_done;
  logic        illegal;
  logic [31:0] instr_count;
  logic [3:0]  state;

  multicycle_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .funct       (funct),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .iord        (iord),
    .ir_we       (ir_we),
    .pc_we       (pc_we),
    .pc_src      (pc_src),
    .alu_srcA    (alu_srcA),
    .alu_srcB    (alu_srcB),
    .alu_op      (alu_op),
    .reg_we      (reg_we),
    .reg_dst     (reg_dst),
    .wd_sel      (wd_sel),
    .instr_done  (instr_done),
    .illegal     (illegal),
    .instr_count (instr_count),
    .state       (state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed vector: {req,we,iord,ir_we,pc_we,pc_src,srcA,srcB,op,reg_we,reg_dst,wd_sel,done,illegal,state}
  logic [23:0] w_obs;
  assign w_obs = {mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_srcA, alu_srcB, alu_op,
                  reg_we, reg_dst, wd_sel, instr_done, illegal, state};

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        rdy;
    logic [23:0] ev;
  } cyc_t;

  logic [23:0] exp_q[$];
  int          n_checks;
  int          n_fail;
  logic [31:0] exp_count;

  logic [23:0] V_INIT, V_FWAIT, V_FRDY, V_DEC, V_WB_R, V_WB_I, V_HALT;

  function automatic logic [23:0] ev(input int st, req, we, io, irw, pcw, pcs, sa, sb, op,
                                     rw, rd, wd, dn, il);
    return {req[0], we[0], io[0], irw[0], pcw[0], pcs[1:0], sa[0], sb[1:0], op[2:0],
            rw[0], rd[1:0], wd[1:0], dn[0], il[0], st[3:0]};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic cyc_t mk(input logic [5:0] op, fn, input logic z, rdy, input logic [23:0] e);
    cyc_t c;
    c.op = op; c.fn = fn; c.z = z; c.rdy = rdy; c.ev = e;
    return c;
  endfunction

  // Driver: apply one cycle of inputs, queue its expected outputs, move to the sample point.
  task automatic drive(input cyc_t c);
    opcode    = c.op;
    funct     = c.fn;
    zero      = c.z;
    mem_ready = c.rdy;
    exp_q.push_back(c.ev);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [23:0] want;
    reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    exp_q.push_back(V_INIT);
    @(negedge clk);
    want = exp_q.pop_front(); n_checks++;
    if (w_obs !== want) begin n_fail++; $display("FAIL reset_hold: got %h expected %h", w_obs, want); end
    n_checks++;
    if (instr_count !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", instr_count); end
    @(posedge clk); #1; reset = 1'b0;
    drive(mk(6'h0, 6'h0, 1'b0, 1'b1, V_INIT));
    want = exp_q.pop_front(); n_checks++;
    if (w_obs !== want) begin n_fail++; $display("FAIL reset_init: got %h expected %h", w_obs, want); end
    @(posedge clk); #1;
    drive(mk(6'h0, 6'h0, 1'b0, 1'b0, V_FWAIT));
    want = exp_q.pop_front(); n_checks++;
    if (w_obs !== want) begin n_fail++; $display("FAIL reset_fetchwait: got %h expected %h", w_obs, want); end
    #1; reset = 1'b1;
    exp_q.push_back(V_INIT);
    #1;
    want = exp_q.pop_front(); n_checks++;
    if (w_obs !== want) begin n_fail++; $display("FAIL reset_async_drop: got %h expected %h", w_obs, want); end
    @(posedge clk); #1; reset = 1'b0;
    drive(mk(6'h0, 6'h0, 1'b0, 1'b0, V_INIT));
    want = exp_q.pop_front(); n_checks++;
    if (w_obs !== want) begin n_fail++; $display("FAIL reset_release0: got %h expected %h", w_obs, want); end
    @(posedge clk); #1;
    drive(mk(6'h0, 6'h0, 1'b0, 1'b0, V_FWAIT));
    want = exp_q.pop_front(); n_checks++;
    if (w_obs !== want) begin n_fail++; $display("FAIL reset_release1: got %h expected %h", w_obs, want); end
    n_checks++;
    if (instr_count !== 32'd0) begin n_fail++; $display("FAIL reset_count2: got %0d expected 0", instr_count); end
    @(posedge clk); #1;
    exp_count = 32'd0;
  endtask

  // Runs a sequence starting in FETCH, then checks state returns to FETCH and the count.
  task automatic test_add();
    cyc_t seq[$];
    logic [23:0] got, want;
    seq.push_back(mk(6'h00, 6'h20, rb(), 1'b1, V_FRDY));
    seq.push_back(mk(6'h00, 6'h20, rb(), rb(), V_DEC));
    seq.push_back(mk(6'h00, 6'h20, rb(), rb(), ev(3, 0,0,0,0,0, 0, 1,0,0, 0,0,0, 0,0)));
    seq.push_back(mk(6'h00, 6'h20, rb(), rb(), V_WB_R));
    exp_count = exp_count + 32'd1;
    foreach (seq[i]) begin
      drive(seq[i]);
      got = w_obs; want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL add[%0d]: got %h expected %h", i, got, want); end
      @(posedge clk); #1;
    end
    n_checks++;
    if (state !== 4'd1) begin n_fail++; $display("FAIL add_end_state: got %0d expected 1", state); end
    n_checks++;
    if (instr_count !== exp_count) begin n_fail++; $display("FAIL add_count: got %0d expected %0d", instr_count, exp_count); end
  endtask

  task automatic test_lw_waits();
    cyc_t seq[$];
    logic [23:0] got, want, v_rd;
    v_rd = ev(6, 1,0,1,0,0, 0, 0,0,0, 0,0,0, 0,0);
    seq.push_back(mk(6'h23, 6'h00, rb(), 1'b0, V_FWAIT));
    seq.push_back(mk(6'h23, 6'h00, rb(), 1'b0, V_FWAIT));
    seq.push_back(mk(6'h23, 6'h00, rb(), 1'b1, V_FRDY));
    seq.push_back(mk(6'h23, 6'h00, rb(), rb(), V_DEC));
    seq.push_back(mk(6'h23, 6'h00, rb(), rb(), ev(5, 0,0,0,0,0, 0, 1,2,0, 0,0,0, 0,0)));
    seq.push_back(mk(6'h23, 6'h00, rb(), 1'b0, v_rd));
    seq.push_back(mk(6'h23, 6'h00, rb(), 1'b0, v_rd));
    seq.push_back(mk(6'h23, 6'h00, rb(), 1'b1, v_rd));
    seq.push_back(mk(6'h23, 6'h00, rb(), rb(), ev(8, 0,0,0,0,0, 0, 0,0,0, 1,0,0, 1,0)));
    exp_count = exp_count + 32'd1;
    foreach (seq[i]) begin
      drive(seq[i]);
      got = w_obs; want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL lw[%0d]: got %h expected %h", i, got, want); end
      @(posedge clk); #1;
    end
    n_checks++;
    if (state !== 4'd1) begin n_fail++; $display("FAIL lw_end_state: got %0d expected 1", state); end
    n_checks++;
    if (instr_count !== exp_count) begin n_fail++; $display("FAIL lw_count: got %0d expected %0d", instr_count, exp_count); end
  endtask

  task automatic test_branch();
    cyc_t seq[$];
    logic [23:0] got, want;
    logic [5:0]  ops[4];
    logic        zs[4];
    int          pws[4];
    ops = '{6'h04, 6'h04, 6'h05, 6'h05};
    zs  = '{1'b1, 1'b0, 1'b0, 1'b1};
    pws = '{1, 0, 1, 0};
    for (int k = 0; k < 4; k++) begin
      seq.push_back(mk(ops[k], 6'h3F, zs[k], 1'b1, V_FRDY));
      seq.push_back(mk(ops[k], 6'h3F, zs[k], rb(), V_DEC));
      seq.push_back(mk(ops[k], 6'h3F, zs[k], rb(), ev(10, 0,0,0,0,pws[k], 3, 1,0,1, 0,0,0, 1,0)));
    end
    exp_count = exp_count + 32'd4;
    foreach (seq[i]) begin
      drive(seq[i]);
      got = w_obs; want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL branch[%0d]: got %h expected %h", i, got, want); end
      @(posedge clk); #1;
    end
    n_checks++;
    if (instr_count !== exp_count) begin n_fail++; $display("FAIL branch_count: got %0d expected %0d", instr_count, exp_count); end
  endtask

  task automatic test_jal_jr();
    cyc_t seq[$];
    logic [23:0] got, want;
    seq.push_back(mk(6'h03, 6'h00, rb(), 1'b1, V_FRDY));
    seq.push_back(mk(6'h03, 6'h00, rb(), rb(), V_DEC));
    seq.push_back(mk(6'h03, 6'h00, rb(), rb(), ev(12, 0,0,0,0,1, 1, 0,0,0, 1,2,2, 1,0)));
    seq.push_back(mk(6'h00, 6'h08, rb(), 1'b1, V_FRDY));
    seq.push_back(mk(6'h00, 6'h08, rb(), rb(), V_DEC));
    seq.push_back(mk(6'h00, 6'h08, rb(), rb(), ev(13, 0,0,0,0,1, 2, 0,0,0, 0,0,0, 1,0)));
    exp_count = exp_count + 32'd2;
    foreach (seq[i]) begin
      drive(seq[i]);
      got = w_obs; want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL jal_jr[%0d]: got %h expected %h", i, got, want); end
      @(posedge clk); #1;
    end
    n_checks++;
    if (instr_count !== exp_count) begin n_fail++; $display("FAIL jal_jr_count: got %0d expected %0d", instr_count, exp_count); end
  endtask

  // sub, slt, addi, xori, sw (one write wait), j issued back to back.
  task automatic test_back_to_back();
    cyc_t seq[$];
    logic [23:0] got, want, v_wr;
    v_wr = ev(7, 1,1,1,0,0, 0, 0,0,0, 0,0,0, 0,0);
    seq.push_back(mk(6'h00, 6'h22, rb(), 1'b1, V_FRDY));
    seq.push_back(mk(6'h00, 6'h22, rb(), rb(), V_DEC));
    seq.push_back(mk(6'h00, 6'h22, rb(), rb(), ev(3, 0,0,0,0,0, 0, 1,0,1, 0,0,0, 0,0)));
    seq.push_back(mk(6'h00, 6'h22, rb(), rb(), V_WB_R));
    seq.push_back(mk(6'h00, 6'h2A, rb(), 1'b1, V_FRDY));
    seq.push_back(mk(6'h00, 6'h2A, rb(), rb(), V_DEC));
    seq.push_back(mk(6'h00, 6'h2A, rb(), rb(), ev(3, 0,0,0,0,0, 0, 1,0,3, 0,0,0, 0,0)));
    seq.push_back(mk(6'h00, 6'h2A, rb(), rb(), V_WB_R));
    seq.push_back(mk(6'h08, 6'h20, rb(), 1'b1, V_FRDY));
    seq.push_back(mk(6'h08, 6'h20, rb(), rb(), V_DEC));
    seq.push_back(mk(6'h08, 6'h20, rb(), rb(), ev(4, 0,0,0,0,0, 0, 1,2,0, 0,0,0, 0,0)));
    seq.push_back(mk(6'h08, 6'h20, rb(), rb(), V_WB_I));
    seq.push_back(mk(6'h0E, 6'h22, rb(), 1'b1, V_FRDY));
    seq.push_back(mk(6'h0E, 6'h22, rb(), rb(), V_DEC));
    seq.push_back(mk(6'h0E, 6'h22, rb(), rb(), ev(4, 0,0,0,0,0, 0, 1,2,2, 0,0,0, 0,0)));
    seq.push_back(mk(6'h0E, 6'h22, rb(), rb(), V_WB_I));
    seq.push_back(mk(6'h2B, 6'h00, rb(), 1'b1, V_FRDY));
    seq.push_back(mk(6'h2B, 6'h00, rb(), rb(), V_DEC));
    seq.push_back(mk(6'h2B, 6'h00, rb(), rb(), ev(5, 0,0,0,0,0, 0, 1,2,0, 0,0,0, 0,0)));
    seq.push_back(mk(6'h2B, 6'h00, rb(), 1'b0, v_wr));
    seq.push_back(mk(6'h2B, 6'h00, rb(), 1'b1, ev(7, 1,1,1,0,0, 0, 0,0,0, 0,0,0, 1,0)));
    seq.push_back(mk(6'h02, 6'h00, rb(), 1'b1, V_FRDY));
    seq.push_back(mk(6'h02, 6'h00, rb(), rb(), V_DEC));
    seq.push_back(mk(6'h02, 6'h00, rb(), rb(), ev(11, 0,0,0,0,1, 1, 0,0,0, 0,0,0, 1,0)));
    exp_count = exp_count + 32'd6;
    foreach (seq[i]) begin
      drive(seq[i]);
      got = w_obs; want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL b2b[%0d]: got %h expected %h", i, got, want); end
      @(posedge clk); #1;
    end
    n_checks++;
    if (instr_count !== exp_count) begin n_fail++; $display("FAIL b2b_count: got %0d expected %0d", instr_count, exp_count); end
  endtask

  task automatic test_illegal(input logic [5:0] op, input logic [5:0] fn, input int halt_cycles);
    cyc_t seq[$];
    logic [23:0] got, want;
    seq.push_back(mk(op, fn, rb(), 1'b1, V_FRDY));
    seq.push_back(mk(op, fn, rb(), rb(), V_DEC));
    for (int k = 0; k < halt_cycles; k++) seq.push_back(mk(op, fn, rb(), rb(), V_HALT));
    foreach (seq[i]) begin
      drive(seq[i]);
      got = w_obs; want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL illegal_%h_%h[%0d]: got %h expected %h", op, fn, i, got, want); end
      @(posedge clk); #1;
    end
    n_checks++;
    if (instr_count !== exp_count) begin n_fail++; $display("FAIL illegal_count: got %0d expected %0d", instr_count, exp_count); end
    reset = 1'b1;
    exp_q.push_back(V_INIT);
    #1;
    want = exp_q.pop_front(); n_checks++;
    if (w_obs !== want) begin n_fail++; $display("FAIL halt_reset: got %h expected %h", w_obs, want); end
    @(posedge clk); #1; reset = 1'b0;
    exp_count = 32'd0;
    drive(mk(6'h0, 6'h0, 1'b0, 1'b1, V_INIT));
    want = exp_q.pop_front(); n_checks++;
    if (w_obs !== want) begin n_fail++; $display("FAIL halt_recover_init: got %h expected %h", w_obs, want); end
    @(posedge clk); #1;
    drive(mk(6'h0, 6'h0, 1'b0, 1'b0, V_FWAIT));
    want = exp_q.pop_front(); n_checks++;
    if (w_obs !== want) begin n_fail++; $display("FAIL halt_recover_fetch: got %h expected %h", w_obs, want); end
    n_checks++;
    if (instr_count !== 32'd0) begin n_fail++; $display("FAIL halt_recover_count: got %0d expected 0", instr_count); end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    exp_count = 32'd0;
    V_INIT  = ev(0,  0,0,0,0,0, 0, 0,0,0, 0,0,0, 0,0);
    V_FWAIT = ev(1,  1,0,0,0,0, 0, 0,1,0, 0,0,0, 0,0);
    V_FRDY  = ev(1,  1,0,0,1,1, 0, 0,1,0, 0,0,0, 0,0);
    V_DEC   = ev(2,  0,0,0,0,0, 0, 0,3,0, 0,0,0, 0,0);
    V_WB_R  = ev(9,  0,0,0,0,0, 0, 0,0,0, 1,1,1, 1,0);
    V_WB_I  = ev(9,  0,0,0,0,0, 0, 0,0,0, 1,0,1, 1,0);
    V_HALT  = ev(15, 0,0,0,0,0, 0, 0,0,0, 0,0,0, 0,1);
    test_reset();
    test_add();
    test_lw_waits();
    test_branch();
    test_jal_jr();
    test_back_to_back();
    test_illegal(6'h00, 6'h3F, 3);
    test_add();
    test_illegal(6'h3F, 6'h20, 100);
    test_add();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
